// File: rtl/layer_priority_scheduler.sv
// Per-pixel layer priority mux with a run-time order that only changes at frame
// boundaries, plus a per-frame collision mask for game logic.
module layer_priority_scheduler #(
    parameter int N_LAYERS = 4,
    parameter int IDX_W    = $clog2(N_LAYERS)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [12*N_LAYERS-1:0]    RGB_layers,
    input  logic [N_LAYERS-1:0]       draw_layers,
    input  logic [11:0]               RGB_bg,
    input  logic                      blank,
    input  logic                      startOfFrame,
    input  logic                      cfg_valid,
    input  logic [IDX_W*N_LAYERS-1:0] cfg_order,
    output logic                      cfg_ready,
    output logic                      cfg_err,
    output logic [3:0]                Red_level,
    output logic [3:0]                Green_level,
    output logic [3:0]                Blue_level,
    output logic [N_LAYERS-1:0]       collision_mask,
    output logic                      collision_pulse
);

    localparam int ORD_W = IDX_W * N_LAYERS;

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    function automatic logic [ORD_W-1:0] identity_order();
        logic [ORD_W-1:0] ord;
        for (int p = 0; p < N_LAYERS; p++) ord[p*IDX_W +: IDX_W] = IDX_W'(p);
        return ord;
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [ORD_W-1:0]    r_active_order;
    logic [ORD_W-1:0]    r_shadow_order;
    logic [11:0]         r_rgb;
    logic                r_cfg_err;
    logic [N_LAYERS-1:0] r_acc;
    logic [N_LAYERS-1:0] r_mask;
    logic                r_pulse;

    logic                w_is_perm;
    logic [N_LAYERS-1:0] w_seen;
    logic [11:0]         w_pix;
    logic                w_hit;
    logic                w_multi;
    logic [N_LAYERS-1:0] w_contrib;
    logic [N_LAYERS-1:0] w_acc_all;
    logic                w_load_shadow;
    logic                w_commit;
    logic                w_reject;

    // An order is legal only if each layer index appears exactly once.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_seen    = '0;
        w_is_perm = 1'b1;
        for (int p = 0; p < N_LAYERS; p++) begin
            if (int'(cfg_order[p*IDX_W +: IDX_W]) >= N_LAYERS) begin
                w_is_perm = 1'b0;
            end else begin
                if (w_seen[cfg_order[p*IDX_W +: IDX_W]]) w_is_perm = 1'b0;
                w_seen[cfg_order[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pix = RGB_bg;
        w_hit = 1'b0;
        for (int p = 0; p < N_LAYERS; p++) begin
            if (!w_hit && draw_layers[r_active_order[p*IDX_W +: IDX_W]]) begin
                w_pix = RGB_layers[12*r_active_order[p*IDX_W +: IDX_W] +: 12];
                w_hit = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more layers draw.
    assign w_multi   = |(draw_layers & (draw_layers - N_LAYERS'(1)));
    assign w_contrib = (!blank && w_multi) ? draw_layers : '0;
    assign w_acc_all = r_acc | w_contrib;

    always_comb begin
        w_next_state  = r_state;
        w_load_shadow = 1'b0;
        w_commit      = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (w_is_perm) begin
                        w_load_shadow = 1'b1;
                        w_next_state  = S_PENDING;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                if (startOfFrame) begin
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_active_order <= identity_order();
            r_shadow_order <= identity_order();
            r_rgb          <= 12'hFFF;
            r_cfg_err      <= 1'b0;
            r_acc          <= '0;
            r_mask         <= '0;
            r_pulse        <= 1'b0;
        end else begin
            r_rgb     <= blank ? 12'h000 : w_pix;
            r_cfg_err <= w_reject;
            if (w_load_shadow) r_shadow_order <= cfg_order;
            if (w_commit)      r_active_order <= r_shadow_order;
            if (startOfFrame) begin
                r_mask  <= w_acc_all;
                r_pulse <= |w_acc_all;
                r_acc   <= '0;
            end else begin
                r_acc   <= w_acc_all;
                r_pulse <= 1'b0;
            end
        end
    end

    assign cfg_ready       = (r_state == S_IDLE);
    assign cfg_err         = r_cfg_err;
    assign Red_level       = r_rgb[11:8];
    assign Green_level     = r_rgb[7:4];
    assign Blue_level      = r_rgb[3:0];
    assign collision_mask  = r_mask;
    assign collision_pulse = r_pulse;

endmodule

// File: tb/tb_layer_priority_scheduler.sv
// Bench for layer_priority_scheduler: directed literal checks, then random
// traffic compared every cycle against an array-based reference model.
module tb_layer_priority_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              resetN;
    logic [12*N-1:0]   RGB_layers;
    logic [N-1:0]      draw_layers;
    logic [11:0]       RGB_bg;
    logic              blank;
    logic              startOfFrame;
    logic              cfg_valid;
    logic [IW*N-1:0]   cfg_order;
    logic              cfg_ready;
    logic              cfg_err;
    logic [3:0]        Red_level;
    logic [3:0]        Green_level;
    logic [3:0]        Blue_level;
    logic [N-1:0]      collision_mask;
    logic              collision_pulse;

    always #5 clk = ~clk;

    layer_priority_scheduler #(.N_LAYERS(N)) dut (
        .clk(clk), .resetN(resetN), .RGB_layers(RGB_layers), .draw_layers(draw_layers),
        .RGB_bg(RGB_bg), .blank(blank), .startOfFrame(startOfFrame),
        .cfg_valid(cfg_valid), .cfg_order(cfg_order), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .Red_level(Red_level), .Green_level(Green_level),
        .Blue_level(Blue_level), .collision_mask(collision_mask),
        .collision_pulse(collision_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_perm(input logic [IW*N-1:0] ord);
        int cnt[N];
        foreach (cnt[i]) cnt[i] = 0;
        for (int p = 0; p < N; p++) begin
            int v;
            v = int'(ord[p*IW +: IW]);
            if (v >= N) return 1'b0;
            cnt[v]++;
        end
        foreach (cnt[i]) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: layer order as an int array, priorities scanned directly.
    int          m_act[N];
    int          m_shadow[N];
    bit          m_pending;
    logic [11:0] m_rgb;
    logic [N-1:0] m_acc, m_mask;
    bit          m_pulse, m_err;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        logic [N-1:0] contrib;
        bit hit;
        if (!resetN) begin
            foreach (m_act[i]) begin m_act[i] = i; m_shadow[i] = i; end
            m_pending = 1'b0; m_rgb = 12'hFFF; m_acc = '0; m_mask = '0;
            m_pulse = 1'b0; m_err = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            hit = 1'b0;
            m_rgb = RGB_bg;
            for (int p = 0; p < N; p++)
                if (!hit && draw_layers[m_act[p]]) begin
                    m_rgb = RGB_layers[12*m_act[p] +: 12];
                    hit = 1'b1;
                end
            if (blank) m_rgb = 12'h000;
            contrib = (!blank && $countones(draw_layers) >= 2) ? draw_layers : '0;
            m_err = !m_pending && cfg_valid && !is_perm(cfg_order);
            if (startOfFrame) begin
                m_mask  = m_acc | contrib;
                m_pulse = (m_mask != 0);
                m_acc   = '0;
            end else begin
                m_acc   = m_acc | contrib;
                m_pulse = 1'b0;
            end
            if (m_pending) begin
                if (startOfFrame) begin m_act = m_shadow; m_pending = 1'b0; end
            end else if (cfg_valid && is_perm(cfg_order)) begin
                for (int p = 0; p < N; p++) m_shadow[p] = int'(cfg_order[p*IW +: IW]);
                m_pending = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("rgb", {20'h0, Red_level, Green_level, Blue_level}, {20'h0, m_rgb});
            check("cfg_ready", {31'h0, cfg_ready}, {31'h0, !m_pending});
            check("cfg_err", {31'h0, cfg_err}, {31'h0, m_err});
            check("collision_mask", {28'h0, collision_mask}, {28'h0, m_mask});
            check("collision_pulse", {31'h0, collision_pulse}, {31'h0, m_pulse});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [11:0] rgb_out();
        return {Red_level, Green_level, Blue_level};
    endfunction

    initial begin
        resetN = 1'b0; blank = 1'b0; startOfFrame = 1'b0; cfg_valid = 1'b0; cfg_order = '0;
        draw_layers = '0; RGB_bg = 12'h123;
        RGB_layers = {12'h888, 12'hF00, 12'h0F0, 12'h00F};
        tick(); tick();
        check("reset_rgb", {20'h0, rgb_out()}, 32'hFFF);
        check("reset_ready", {31'h0, cfg_ready}, 32'h1);
        check("reset_err", {31'h0, cfg_err}, 32'h0);
        check("reset_mask", {28'h0, collision_mask}, 32'h0);
        check("reset_pulse", {31'h0, collision_pulse}, 32'h0);
        resetN = 1'b1;

        draw_layers = 4'b0110; tick();
        check("identity_pix", {20'h0, rgb_out()}, 32'h0F0);
        blank = 1'b1; tick();
        check("blank_pix", {20'h0, rgb_out()}, 32'h000);
        blank = 1'b0; draw_layers = 4'b0000; tick();
        check("bg_pix", {20'h0, rgb_out()}, 32'h123);

        // Order {p0=2,p1=1,p2=0,p3=3} offered mid-frame.
        draw_layers = 4'b0110; cfg_valid = 1'b1; cfg_order = 8'hC6; tick();
        check("pend_ready", {31'h0, cfg_ready}, 32'h0);
        check("pend_pix", {20'h0, rgb_out()}, 32'h0F0);
        cfg_valid = 1'b0; tick();
        check("pend_pix2", {20'h0, rgb_out()}, 32'h0F0);
        startOfFrame = 1'b1; tick();
        check("commit_ready", {31'h0, cfg_ready}, 32'h1);
        check("commit_mask", {28'h0, collision_mask}, 32'h6);
        check("commit_pulse", {31'h0, collision_pulse}, 32'h1);
        startOfFrame = 1'b0; tick();
        check("new_order_pix", {20'h0, rgb_out()}, 32'hF00);
        check("pulse_drop", {31'h0, collision_pulse}, 32'h0);

        // Duplicate order {1,1,0,3} is rejected.
        cfg_valid = 1'b1; cfg_order = 8'hC5; tick();
        check("dup_err", {31'h0, cfg_err}, 32'h1);
        check("dup_ready", {31'h0, cfg_ready}, 32'h1);
        check("dup_pix", {20'h0, rgb_out()}, 32'hF00);
        cfg_valid = 1'b0; tick();
        check("dup_err_drop", {31'h0, cfg_err}, 32'h0);

        // Collisions: only visible overlaps count.
        draw_layers = 4'b0000; startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0; draw_layers = 4'b1001;
        tick();
        check("order_layer0", {20'h0, rgb_out()}, 32'h00F);
        tick(); tick();
        blank = 1'b1; draw_layers = 4'b0110; tick(); tick();
        blank = 1'b0; draw_layers = 4'b0000; startOfFrame = 1'b1; tick();
        check("coll_mask", {28'h0, collision_mask}, 32'h9);
        check("coll_pulse", {31'h0, collision_pulse}, 32'h1);
        startOfFrame = 1'b0; draw_layers = 4'b0001; tick(); tick();
        check("coll_pulse_once", {31'h0, collision_pulse}, 32'h0);
        startOfFrame = 1'b1; tick();
        check("no_coll_mask", {28'h0, collision_mask}, 32'h0);
        check("no_coll_pulse", {31'h0, collision_pulse}, 32'h0);

        // Offer and frame start in the same cycle: commit waits a frame.
        draw_layers = 4'b0110; cfg_valid = 1'b1; cfg_order = 8'hE4; tick();
        check("same_ready", {31'h0, cfg_ready}, 32'h0);
        cfg_valid = 1'b0; startOfFrame = 1'b0; tick();
        check("same_pix", {20'h0, rgb_out()}, 32'hF00);
        startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0; tick();
        check("same_commit_pix", {20'h0, rgb_out()}, 32'h0F0);

        // Reset while an order is pending.
        cfg_valid = 1'b1; cfg_order = 8'hC6; tick();
        cfg_valid = 1'b0; resetN = 1'b0; tick();
        check("rst_pend_rgb", {20'h0, rgb_out()}, 32'hFFF);
        check("rst_pend_ready", {31'h0, cfg_ready}, 32'h1);
        resetN = 1'b1; tick();
        check("rst_identity_pix", {20'h0, rgb_out()}, 32'h0F0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            resetN       = ($urandom_range(499, 0) != 0);
            RGB_layers   = 48'({$urandom(), $urandom()});
            RGB_bg       = 12'($urandom());
            draw_layers  = N'($urandom());
            blank        = ($urandom_range(3, 0) == 0);
            startOfFrame = ($urandom_range(29, 0) == 0);
            cfg_valid    = ($urandom_range(7, 0) == 0);
            if ($urandom_range(1, 0) == 0) begin
                int a[N];
                foreach (a[i]) a[i] = i;
                for (int i = N - 1; i > 0; i--) begin
                    int j, t;
                    j = $urandom_range(i, 0);
                    t = a[i]; a[i] = a[j]; a[j] = t;
                end
                for (int p = 0; p < N; p++) cfg_order[p*IW +: IW] = IW'(a[p]);
            end else begin
                cfg_order = (IW*N)'($urandom());
            end
            tick();
        end
        resetN = 1'b1; cfg_valid = 1'b0; startOfFrame = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
